// File: rtl/gcd_sweep_master.sv
// gcd_sweep_master: walks every (a,b) pair in 1..MAXOP through one GCD engine
// and accumulates pair count, coprime count and result sum.
module gcd_sweep_master #(
   parameter int W       = 10,
   parameter int MAXOP   = 10,
   parameter int TIMEOUT = 4095
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   output logic             gcd_start,
   output logic [W-1:0]     gcd_a,
   output logic [W-1:0]     gcd_b,
   input  logic [W-1:0]     gcd_result,
   input  logic             gcd_result_ready,
   output logic             busy,
   output logic             done,
   output logic             timeout_err,
   output logic [2*W-1:0]   coprime_count,
   output logic [3*W-1:0]   result_sum,
   output logic [2*W-1:0]   pair_count
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [W-1:0]  MAX   = W'(MAXOP);
   localparam logic [W-1:0]  ONE   = W'(1);
   localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_ACCUM,
      S_DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] wcnt;
   logic [W-1:0]  res_q;
   logic          last_pair;

   assign last_pair = (gcd_a == MAX) && (gcd_b == MAX);

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         wcnt          <= '0;
         res_q         <= '0;
         gcd_start     <= 1'b0;
         gcd_a         <= '0;
         gcd_b         <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         timeout_err   <= 1'b0;
         coprime_count <= '0;
         result_sum    <= '0;
         pair_count    <= '0;
      end else begin
         unique case (state)
            S_IDLE, S_DONE: begin
               if (go) begin
                  gcd_a         <= ONE;
                  gcd_b         <= ONE;
                  coprime_count <= '0;
                  result_sum    <= '0;
                  pair_count    <= '0;
                  timeout_err   <= 1'b0;
                  wcnt          <= '0;
                  gcd_start     <= 1'b1;
                  busy          <= 1'b1;
                  done          <= 1'b0;
                  state         <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               gcd_start <= 1'b0;
               wcnt      <= '0;
               state     <= S_WAIT;
            end
            S_WAIT: begin
               // ready takes priority over an expiring wait counter
               if (gcd_result_ready) begin
                  res_q <= gcd_result;
                  state <= S_ACCUM;
               end else if (wcnt == TLAST) begin
                  timeout_err <= 1'b1;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            S_ACCUM: begin
               pair_count <= pair_count + 1'b1;
               result_sum <= result_sum + {{(2*W){1'b0}}, res_q};
               if (res_q == ONE)
                  coprime_count <= coprime_count + 1'b1;
               if (gcd_b < MAX) begin
                  gcd_b <= gcd_b + 1'b1;
               end else begin
                  gcd_b <= ONE;
                  gcd_a <= gcd_a + 1'b1;
               end
               if (last_pair) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  gcd_start <= 1'b1;
                  state     <= S_ISSUE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_sweep_master.sv
// Directed bench for gcd_sweep_master: three sweepers (MAXOP 10/3/2), each
// driving its own behavioural GCD engine with a fixed five-cycle latency.
module tb_gcd_sweep_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        go   [3];
   logic        st   [3];
   logic [9:0]  ga   [3];
   logic [9:0]  gb   [3];
   logic [9:0]  res  [3];
   logic        rdy  [3] = '{1'b1, 1'b1, 1'b1};
   logic        busy [3];
   logic        done [3];
   logic        err  [3];
   logic [19:0] cop  [3];
   logic [19:0] pc   [3];
   logic [29:0] sum  [3];
   logic [9:0]  la   [3];
   logic [9:0]  lb   [3];
   int          cnt  [3] = '{0, 0, 0};
   bit          stuck[3];

   int n_cmp = 0;
   int n_bad = 0;

   gcd_sweep_master #(.W(10), .MAXOP(10), .TIMEOUT(20)) d10 (
      .clk(clk), .reset(reset), .go(go[0]), .gcd_start(st[0]),
      .gcd_a(ga[0]), .gcd_b(gb[0]), .gcd_result(res[0]),
      .gcd_result_ready(rdy[0]), .busy(busy[0]), .done(done[0]),
      .timeout_err(err[0]), .coprime_count(cop[0]),
      .result_sum(sum[0]), .pair_count(pc[0]));

   gcd_sweep_master #(.W(10), .MAXOP(3)) d3 (
      .clk(clk), .reset(reset), .go(go[1]), .gcd_start(st[1]),
      .gcd_a(ga[1]), .gcd_b(gb[1]), .gcd_result(res[1]),
      .gcd_result_ready(rdy[1]), .busy(busy[1]), .done(done[1]),
      .timeout_err(err[1]), .coprime_count(cop[1]),
      .result_sum(sum[1]), .pair_count(pc[1]));

   gcd_sweep_master #(.W(10), .MAXOP(2)) d2 (
      .clk(clk), .reset(reset), .go(go[2]), .gcd_start(st[2]),
      .gcd_a(ga[2]), .gcd_b(gb[2]), .gcd_result(res[2]),
      .gcd_result_ready(rdy[2]), .busy(busy[2]), .done(done[2]),
      .timeout_err(err[2]), .coprime_count(cop[2]),
      .result_sum(sum[2]), .pair_count(pc[2]));

   function automatic logic [9:0] gcdf(input logic [9:0] x, input logic [9:0] y);
      logic [9:0] t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // engine: drops ready when started, raises it with the result 5 edges later
   for (genvar g = 0; g < 3; g++) begin : eng
      always @(posedge clk) begin
         if (st[g]) begin
            la[g]  <= ga[g];
            lb[g]  <= gb[g];
            rdy[g] <= 1'b0;
            cnt[g] <= 5;
         end else if (!rdy[g] && !stuck[g] && cnt[g] > 0) begin
            if (cnt[g] == 1) begin
               rdy[g] <= 1'b1;
               res[g] <= gcdf(la[g], lb[g]);
            end
            cnt[g] <= cnt[g] - 1;
         end
      end
   end

   logic [19:0] order_q[$];
   always @(posedge clk)
      if (st[1]) order_q.push_back({ga[1], gb[1]});

   int c_starts = 0;
   int c_dbl = 0;
   int c_viol = 0;
   int c_busy = 0;
   logic prev_st = 1'b0;
   logic [9:0] ha = '0;
   logic [9:0] hb = '0;
   always @(posedge clk) begin
      if (st[2]) begin
         c_starts++;
         ha = ga[2];
         hb = gb[2];
      end else if (busy[2] && (ga[2] != ha || gb[2] != hb)) begin
         c_viol++;
      end
      if (busy[2]) c_busy++;
      if (prev_st && st[2]) c_dbl++;
      prev_st = st[2];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_go(input int i);
      @(negedge clk);
      go[i] = 1'b1;
      @(negedge clk);
      go[i] = 1'b0;
   endtask

   task automatic wait_done(input int i, input int lim);
      int n;
      n = 0;
      while (done[i] !== 1'b1 && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk("done_reached", 64'(done[i] === 1'b1), 1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_start"}, 64'(st[0]), 0);
      chk({tag, "_a"}, 64'(ga[0]), 0);
      chk({tag, "_b"}, 64'(gb[0]), 0);
      chk({tag, "_busy"}, 64'(busy[0]), 0);
      chk({tag, "_done"}, 64'(done[0]), 0);
      chk({tag, "_err"}, 64'(err[0]), 0);
      chk({tag, "_cop"}, 64'(cop[0]), 0);
      chk({tag, "_sum"}, 64'(sum[0]), 0);
      chk({tag, "_pairs"}, 64'(pc[0]), 0);
   endtask

   task automatic chk_full10(input string tag);
      chk({tag, "_pairs"}, 64'(pc[0]), 100);
      chk({tag, "_cop"}, 64'(cop[0]), 63);
      chk({tag, "_sum"}, 64'(sum[0]), 189);
      chk({tag, "_err"}, 64'(err[0]), 0);
      chk({tag, "_busy"}, 64'(busy[0]), 0);
   endtask

   initial begin
      int nb;
      int k;
      bit found;
      logic [19:0] exp_pair;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         go[i] = 1'b0;
         stuck[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk_zero("rst");

      // full 10x10 sweep, with stray go pulses while busy
      pulse_go(0);
      chk("busy_after_go", 64'(busy[0]), 1);
      chk("done_after_go", 64'(done[0]), 0);
      repeat (30) @(negedge clk);
      go[0] = 1'b1;
      @(negedge clk);
      go[0] = 1'b0;
      chk("go_ignored_busy", 64'(busy[0]), 1);
      wait_done(0, 5000);
      chk_full10("s10");

      // MAXOP=3: counts and issue order
      pulse_go(1);
      wait_done(1, 2000);
      chk("s3_pairs", 64'(pc[1]), 9);
      chk("s3_cop", 64'(cop[1]), 7);
      chk("s3_sum", 64'(sum[1]), 12);
      chk("s3_order_len", 64'(order_q.size()), 9);
      k = 0;
      for (int a = 1; a <= 3; a++)
         for (int b = 1; b <= 3; b++) begin
            exp_pair = {10'(a), 10'(b)};
            if (k < order_q.size())
               chk("s3_order", 64'(order_q[k]), 64'(exp_pair));
            k++;
         end

      // MAXOP=2 handshake: 4 pulses, stable operands, 8 cycles per pair
      pulse_go(2);
      wait_done(2, 2000);
      chk("hs_starts", 64'(c_starts), 4);
      chk("hs_double", 64'(c_dbl), 0);
      chk("hs_stable", 64'(c_viol), 0);
      chk("hs_busy_cycles", 64'(c_busy), 32);
      chk("hs_pairs", 64'(pc[2]), 4);
      chk("hs_sum", 64'(sum[2]), 5);
      chk("hs_cop", 64'(cop[2]), 3);
      chk("hs_excl", 64'(busy[2] & done[2]), 0);

      // stuck engine, TIMEOUT=20
      stuck[0] = 1'b1;
      pulse_go(0);
      nb = 0;
      while (done[0] !== 1'b1 && nb < 200) begin
         if (busy[0]) nb++;
         @(negedge clk);
      end
      chk("to_busy_cycles", 64'(nb), 21);
      chk("to_err", 64'(err[0]), 1);
      chk("to_done", 64'(done[0]), 1);
      chk("to_pairs", 64'(pc[0]), 0);
      chk("to_busy", 64'(busy[0]), 0);
      stuck[0] = 1'b0;
      pulse_go(0);
      chk("to_err_cleared", 64'(err[0]), 0);
      chk("to_done_cleared", 64'(done[0]), 0);
      wait_done(0, 5000);
      chk_full10("rerun");

      // reset during WAIT of (2,3), coincident with go
      pulse_go(0);
      found = 1'b0;
      nb = 0;
      while (!found && nb < 1000) begin
         @(negedge clk);
         nb++;
         found = (st[0] === 1'b1 && ga[0] == 10'd2 && gb[0] == 10'd3);
      end
      chk("found_pair_2_3", 64'(found), 1);
      @(negedge clk);
      chk("in_wait", 64'(st[0]), 0);
      reset = 1'b1;
      go[0] = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      go[0] = 1'b0;
      chk_zero("midrst");
      @(negedge clk);
      chk("reset_beats_go", 64'(busy[0]), 0);
      pulse_go(0);
      wait_done(0, 5000);
      chk_full10("after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
